// File: rtl/video_pkg.sv
// video_pkg: shared raster geometry defaults and video output FSM state type
package video_pkg;
    localparam int p_WIDTH  = 640;
    localparam int p_HEIGHT = 480;
    localparam int H_BLANK  = 160;
    localparam int V_BLANK  = 40;
    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} vout_state_t;
endpackage

// File: rtl/video_timing_cnt.sv
// video_timing_cnt: horizontal/vertical raster counters with terminal-count flags
module video_timing_cnt #(
    parameter int p_WIDTH  = video_pkg::p_WIDTH,
    parameter int p_HEIGHT = video_pkg::p_HEIGHT,
    parameter int H_BLANK  = video_pkg::H_BLANK,
    parameter int V_BLANK  = video_pkg::V_BLANK
) (
    input  logic                   clk,
    input  logic                   nRST,
    input  video_pkg::vout_state_t state,
    output logic                   h_last,
    output logic                   v_last,
    output logic                   vb_last
);
    import video_pkg::*;
    localparam int VBT = V_BLANK * (p_WIDTH + H_BLANK);
    localparam int HW  = $clog2((p_WIDTH > H_BLANK ? p_WIDTH : H_BLANK) + 1);
    localparam int VW  = $clog2((VBT > p_HEIGHT ? VBT : p_HEIGHT) + 1);
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    always_comb begin
        h_last  = (state == ACTIVE && h_cnt == HW'(p_WIDTH - 1)) ||
                  (state == HBLANK && h_cnt == HW'(H_BLANK - 1));
        v_last  = v_cnt == VW'(p_HEIGHT - 1);
        vb_last = state == VBLANK && v_cnt == VW'(VBT - 1);
    end
    // v_cnt doubles as the flat blanking counter during VBLANK
    always_ff @(posedge clk) begin
        if (!nRST) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= (state == ACTIVE || state == HBLANK) && !h_last ? h_cnt + 1'b1 : '0;
            v_cnt <= state == HBLANK && h_last ? (v_last ? '0 : v_cnt + 1'b1)
                   : state == VBLANK ? (vb_last ? '0 : v_cnt + 1'b1)
                   : state == IDLE ? '0 : v_cnt;
        end
    end
endmodule

// File: rtl/video_out_gen.sv
// video_out_gen: pops grey pixels from a FWFT FIFO and drives a fixed-timing raster stream
module video_out_gen #(
    parameter int p_WIDTH  = video_pkg::p_WIDTH,
    parameter int p_HEIGHT = video_pkg::p_HEIGHT,
    parameter int H_BLANK  = video_pkg::H_BLANK,
    parameter int V_BLANK  = video_pkg::V_BLANK
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       enable,
    input  logic       empty,
    input  logic [7:0] data_in,
    output logic       r_e,
    output logic [7:0] pixel_out,
    output logic       line_valid,
    output logic       frame_valid,
    output logic       frame_end,
    output logic       underrun
);
    import video_pkg::*;
    vout_state_t state;
    logic h_last, v_last, vb_last, start;
    assign start = enable && !empty;
    assign r_e   = nRST && state == ACTIVE && !empty;
    video_timing_cnt #(
        .p_WIDTH(p_WIDTH), .p_HEIGHT(p_HEIGHT), .H_BLANK(H_BLANK), .V_BLANK(V_BLANK)
    ) u_cnt (
        .clk(clk), .nRST(nRST), .state(state),
        .h_last(h_last), .v_last(v_last), .vb_last(vb_last)
    );
    // Timing never stalls: an empty FIFO during ACTIVE yields a black pixel and an underrun pulse
    always_ff @(posedge clk) begin
        if (!nRST) begin
            state       <= IDLE;
            pixel_out   <= 8'h00;
            line_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_end   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            pixel_out   <= r_e ? data_in : 8'h00;
            line_valid  <= state == ACTIVE;
            frame_valid <= state == ACTIVE || state == HBLANK;
            underrun    <= state == ACTIVE && empty;
            frame_end   <= vb_last;
            case (state)
                IDLE:    if (start) state <= ACTIVE;
                ACTIVE:  if (h_last) state <= HBLANK;
                HBLANK:  if (h_last && v_last) state <= VBLANK;
                         else if (h_last) state <= ACTIVE;
                default: if (vb_last && start) state <= ACTIVE;
                         else if (vb_last) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_video_out_gen.sv
// tb_video_out_gen: scoreboard bench for video_out_gen on a 4x2 raster with 2/1 blanking
module tb_video_out_gen;
    localparam int W = 4, H = 2, HB = 2, VB = 1;
    typedef struct {logic [7:0] pix; logic und;} pix_t;
    typedef struct {int n_re; int gap;} frame_t;
    logic       clk = 0, nRST = 0, enable = 0, flush = 0;
    logic       empty, r_e, line_valid, frame_valid, frame_end, underrun;
    logic [7:0] data_in, pixel_out;
    logic [7:0] mem [64];
    int         wr_ptr = 0, rd_ptr = 0;
    int         n_checks = 0, n_fail = 0;
    pix_t       pix_q[$];
    frame_t     frame_q[$];

    always #5 clk = ~clk;

    video_out_gen #(.p_WIDTH(W), .p_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
        .clk(clk), .nRST(nRST), .enable(enable), .empty(empty), .data_in(data_in),
        .r_e(r_e), .pixel_out(pixel_out), .line_valid(line_valid),
        .frame_valid(frame_valid), .frame_end(frame_end), .underrun(underrun)
    );

    // FWFT FIFO model
    assign empty   = rd_ptr == wr_ptr;
    assign data_in = mem[rd_ptr[5:0]];
    always @(posedge clk) rd_ptr <= flush ? wr_ptr : rd_ptr + int'(r_e);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic exp_pix(input logic [7:0] v, input logic u);
        pix_q.push_back(pix_t'{v, u});
    endtask

    task automatic wait_rd(input int target);
        for (int i = 0; i < 60 && rd_ptr != target; i++) tick();
        check("fifo_pops_reached", rd_ptr, target);
    endtask

    task automatic wait_fe(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!frame_end && n < 100);
        check(name, int'(frame_end), 1);
    endtask

    // Monitor
    logic [1:0] rst_hist = 2'b11;
    logic       start_s = 0;
    always @(posedge clk) begin
        rst_hist <= {rst_hist[0], nRST};
        start_s  <= enable && !empty;
    end

    int     cyc = 0, start_cyc = 0, last_fe = -100, re_cnt = 0;
    bit     in_frame = 0;
    frame_t cur = '{-1, -1};
    pix_t   p;
    always @(negedge clk) begin
        int off;
        cyc++;
        if (!nRST) check("reset_re", int'(r_e), 0);
        if (!rst_hist[0])
            check("reset_outputs", {pixel_out, line_valid, frame_valid, frame_end, underrun}, 0);
        if (rst_hist == 2'b01 && start_s) check("release_re", int'(r_e), 1);
        if (line_valid && !in_frame) begin
            in_frame  = 1;
            start_cyc = cyc;
            if (frame_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: frame started at cycle %0d, none expected", cyc);
                cur = '{-1, -1};
            end else cur = frame_q.pop_front();
            if (cur.gap >= 0) check("frame_gap", cyc - last_fe, cur.gap);
        end
        if (in_frame) begin
            off = cyc - start_cyc;
            check("frame_timing", {line_valid, frame_valid, frame_end},
                  {off < 12 && off % 6 < 4, off < 12, off == 17});
            if (off == 17) begin
                if (cur.n_re >= 0) check("frame_re_count", re_cnt, cur.n_re);
                in_frame = 0;
                last_fe  = cyc;
                re_cnt   = 0;
            end
        end else check("idle_timing", {frame_valid, frame_end}, 0);
        if (line_valid) begin
            if (pix_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pixel: got 0x%0h, none expected", pixel_out);
            end else begin
                p = pix_q.pop_front();
                check("pixel", {underrun, pixel_out}, {p.und, p.pix});
            end
        end else check("blank_pixel", {underrun, pixel_out}, 0);
        if (!nRST) begin
            in_frame = 0;
            re_cnt   = 0;
        end
        re_cnt += int'(r_e);
    end

    // Stimulus
    initial begin
        int base;
        // reset with enable and a filled FIFO, then two back-to-back frames
        nRST   = 0;
        enable = 1;
        for (int i = 0; i < 8; i++) begin
            push(8'(i + 1));
            exp_pix(8'(i + 1), 0);
        end
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h11 + i));
            exp_pix(8'(8'h11 + i), 0);
        end
        frame_q.push_back('{8, -1});
        frame_q.push_back('{8, 1});
        repeat (3) tick();
        nRST = 1;
        wait_fe("frame_a_end");
        wait_fe("frame_b_end");

        // underrun on the third pixel of line 0
        base = rd_ptr;
        push(8'h01);
        push(8'h02);
        exp_pix(8'h01, 0); exp_pix(8'h02, 0); exp_pix(8'h00, 1); exp_pix(8'h03, 0);
        exp_pix(8'h04, 0); exp_pix(8'h05, 0); exp_pix(8'h06, 0); exp_pix(8'h07, 0);
        frame_q.push_back('{7, -1});
        wait_rd(base + 2);
        tick();
        for (int i = 3; i <= 8; i++) push(8'(i));
        enable = 0;
        wait_fe("frame_c_end");
        tick();
        flush = 1;
        tick();
        flush = 0;

        // enable dropped during line 1 with more data waiting
        enable = 1;
        base = rd_ptr;
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h21 + i));
            exp_pix(8'(8'h21 + i), 0);
        end
        frame_q.push_back('{8, -1});
        wait_rd(base + 5);
        enable = 0;
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        wait_fe("frame_d_end");
        repeat (30) tick();
        check("idle_no_re", re_cnt, 0);
        flush = 1;
        tick();
        flush = 0;

        // reset during line 0, then a fresh frame from the remaining data
        enable = 1;
        base = rd_ptr;
        for (int i = 0; i < 8; i++) push(8'(8'h41 + i));
        for (int i = 0; i < 10; i++) exp_pix(8'(8'h41 + i), 0);
        frame_q.push_back('{-1, -1});
        frame_q.push_back('{8, -1});
        wait_rd(base + 2);
        nRST = 0;
        tick();
        tick();
        push(8'h49);
        push(8'h4A);
        nRST = 1;
        wait_fe("frame_e_end");
        enable = 0;
        repeat (5) tick();
        check("pixels_drained", pix_q.size(), 0);
        check("frames_drained", frame_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
